gray_fifo_ctrl: RTL and testbench
=================================

# gray_fifo_ctrl

Single-clock FIFO pointer controller built on Gray-coded counters. Tracks write and read pointers for an external 2^ADDR_WIDTH-entry memory, gates push/pop requests against full/empty, and drives the memory's write/read enables and addresses. Pointers are also exported in Gray code so a later dual-clock variant can hand them across domains unchanged.

## Interface
- ADDR_WIDTH, 4, memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (extra wrap bit).
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write request.
- pop  input  1  read request.
- wr_en  output  1  memory write strobe (accepted push).
- wr_addr  output  ADDR_WIDTH  memory write address.
- rd_en  output  1  memory read strobe (accepted pop).
- rd_addr  output  ADDR_WIDTH  memory read address.
- wr_ptr_gray  output  ADDR_WIDTH+1  write pointer, Gray code.
- rd_ptr_gray  output  ADDR_WIDTH+1  read pointer, Gray code.
- full  output  1  registered full flag.
- empty  output  1  registered empty flag.
- count  output  ADDR_WIDTH+1  occupancy, 0..2^ADDR_WIDTH.
- err_overflow, err_underflow, err_clr: see Configuration.

## Operation
- State: binary wr_bin, rd_bin (ADDR_WIDTH+1 bits each), Gray registers wr_gray, rd_gray, flags full, empty.
- Accept: wr_en = push & ~full; rd_en = pop & ~empty; combinational from registered flags.
- On wr_en: wr_bin += 1 (mod 2^(ADDR_WIDTH+1)); wr_gray <= next_bin ^ (next_bin >> 1). Same for read side on rd_en.
- wr_addr = wr_bin[ADDR_WIDTH-1:0]; rd_addr = rd_bin[ADDR_WIDTH-1:0].
- Next-state flags from next Gray pointers: empty when wr_gray_next == rd_gray_next; full when wr_gray_next == {~rd_gray_next[top two bits], rd_gray_next[rest]}.
- count = wr_bin - rd_bin, ADDR_WIDTH+1 bits, combinational from registers.
- Simultaneous push & pop: each accepted independently by its own flag. Neither full nor empty: both accepted, count unchanged. Full: pop only. Empty: push only.
- Rejected push/pop: no pointer or memory activity.
- Pointer wrap past 2^(ADDR_WIDTH+1)-1 to 0 is normal; Gray value changes exactly one bit on every increment, including wrap.

## Timing
- Reset (async assert, sync deassert by upstream): all pointers 0, empty=1, full=0, count=0, wr_en=rd_en=0 regardless of push/pop, error flags 0.
- Enables and addresses valid in the same cycle as the request; memory writes at that edge.
- Pointers, Gray outputs, flags, count update at the edge of acceptance; visible the following cycle.
- Reset mid-operation: all state cleared immediately; in-flight enables drop same cycle.

## Configuration
- GRAY_FIFO_CTRL_ERR_EN defined: adds err_clr (input, 1), err_overflow, err_underflow (outputs, 1). err_overflow sets on push & full; err_underflow sets on pop & empty; sticky until err_clr or reset; set wins over simultaneous err_clr.
- Not defined: those three ports absent; rejected requests dropped silently.

## Test plan
- ADDR_WIDTH=2, reset then 4 pushes -> full=1 after 4th, count=4, wr_ptr_gray=3'b110, empty=0.
- Full, push=1 pop=0 -> wr_en=0, pointers unchanged; with GRAY_FIFO_CTRL_ERR_EN err_overflow=1 until err_clr.
- Full, push=1 pop=1 -> rd_en=1, wr_en=0, count=3, full=0 next cycle.
- Empty, pop -> rd_en=0, rd_ptr_gray=0; err_underflow=1 when macro defined.
- 20 cycles push&pop from count=1 -> count stays 1, pointers wrap 7->0, every wr_ptr_gray step differs in exactly one bit.
- Assert reset with count=3 between edges -> empty=1, count=0, wr_en=0 immediately, before next clock edge.

Source files
------------

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller with Gray-coded wr/rd pointers, full/empty/count.
// Optional sticky overflow/underflow flags when GRAY_FIFO_CTRL_ERR_EN is defined. ADDR_WIDTH must be >= 2.
module gray_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
`ifdef GRAY_FIFO_CTRL_ERR_EN
  input  logic                  err_clr,
  output logic                  err_overflow,
  output logic                  err_underflow,
`endif
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] wr_bin_r, rd_bin_r, wr_gray_r, rd_gray_r;
  logic [PW-1:0] wr_bin_next_s, rd_bin_next_s, wr_gray_next_s, rd_gray_next_s;
  logic          full_r, empty_r, full_next_s, empty_next_s;
  logic          wr_en_s, rd_en_s;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Request acceptance against registered flags; reset masks strobes immediately.
  always_comb begin
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    if (reset) begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end else begin
      wr_en_s = push & ~full_r;
      rd_en_s = pop & ~empty_r;
    end
  end

  // Next binary/Gray pointers and the flags they imply.
  always_comb begin
    wr_bin_next_s = wr_bin_r;
    rd_bin_next_s = rd_bin_r;
    if (wr_en_s) begin
      wr_bin_next_s = wr_bin_r + PTR_ONE;
    end else begin
      wr_bin_next_s = wr_bin_r;
    end
    if (rd_en_s) begin
      rd_bin_next_s = rd_bin_r + PTR_ONE;
    end else begin
      rd_bin_next_s = rd_bin_r;
    end
    wr_gray_next_s = bin2gray(wr_bin_next_s);
    rd_gray_next_s = bin2gray(rd_bin_next_s);
    empty_next_s   = (wr_gray_next_s == rd_gray_next_s);
    // In Gray code a full lap differs from the read pointer in its top two bits.
    full_next_s    = (wr_gray_next_s ==
                      {~rd_gray_next_s[PW-1:PW-2], rd_gray_next_s[PW-3:0]});
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bin_r  <= {PW{1'b0}};
      rd_bin_r  <= {PW{1'b0}};
      wr_gray_r <= {PW{1'b0}};
      rd_gray_r <= {PW{1'b0}};
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
    end else begin
      wr_bin_r  <= wr_bin_next_s;
      rd_bin_r  <= rd_bin_next_s;
      wr_gray_r <= wr_gray_next_s;
      rd_gray_r <= rd_gray_next_s;
      full_r    <= full_next_s;
      empty_r   <= empty_next_s;
    end
  end

`ifdef GRAY_FIFO_CTRL_ERR_EN
  logic err_overflow_r, err_underflow_r;

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_overflow_r  <= 1'b0;
      err_underflow_r <= 1'b0;
    end else begin
      if (push & full_r) begin
        err_overflow_r <= 1'b1;
      end else if (err_clr) begin
        err_overflow_r <= 1'b0;
      end else begin
        err_overflow_r <= err_overflow_r;
      end
      if (pop & empty_r) begin
        err_underflow_r <= 1'b1;
      end else if (err_clr) begin
        err_underflow_r <= 1'b0;
      end else begin
        err_underflow_r <= err_underflow_r;
      end
    end
  end

  assign err_overflow  = err_overflow_r;
  assign err_underflow = err_underflow_r;
`endif

  assign wr_en       = wr_en_s;
  assign rd_en       = rd_en_s;
  assign wr_addr     = wr_bin_r[ADDR_WIDTH-1:0];
  assign rd_addr     = rd_bin_r[ADDR_WIDTH-1:0];
  assign wr_ptr_gray = wr_gray_r;
  assign rd_ptr_gray = rd_gray_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign count       = wr_bin_r - rd_bin_r;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Self-checking bench for gray_fifo_ctrl (ADDR_WIDTH=2): occupancy model plus a data scoreboard
// over a bench-side memory driven by the DUT's enables and addresses.
module tb_gray_fifo_ctrl;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          wr_en, rd_en, full, empty;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   wr_ptr_gray, rd_ptr_gray, count;
`ifdef GRAY_FIFO_CTRL_ERR_EN
  logic          err_clr = 1'b0;
  logic          err_overflow, err_underflow;
  logic          m_ovf, m_unf;
`endif

  int            errors = 0;
  int            checks = 0;
  logic [7:0]    wdata;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    sb [$];
  logic [AW:0]   m_wr, m_rd;
  int            m_occ;

  gray_fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
`ifdef GRAY_FIFO_CTRL_ERR_EN
    .err_clr(err_clr), .err_overflow(err_overflow), .err_underflow(err_underflow),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) mem[wr_addr] <= wdata;

  task automatic model_reset();
    m_wr = '0; m_rd = '0; m_occ = 0; sb.delete();
`ifdef GRAY_FIFO_CTRL_ERR_EN
    m_ovf = 1'b0; m_unf = 1'b0;
`endif
  endtask

  // One clock with push/pop; c drives err_clr when the error feature exists.
  task automatic cycle(input logic p, input logic q, input logic c);
    logic       ew, er;
    logic [7:0] got, expd;
    logic [AW:0] gw, gr;
    @(negedge clk);
    push = p; pop = q; wdata = 8'($urandom);
`ifdef GRAY_FIFO_CTRL_ERR_EN
    err_clr = c;
`else
    if (c) wdata = wdata;
`endif
    #1;
    ew = p && (m_occ != DEPTH);
    er = q && (m_occ != 0);
    checks++; if (wr_en !== ew) begin errors++; $display("FAIL wr_en: got %b expected %b", wr_en, ew); end
    checks++; if (rd_en !== er) begin errors++; $display("FAIL rd_en: got %b expected %b", rd_en, er); end
    checks++; if (wr_addr !== m_wr[AW-1:0]) begin errors++; $display("FAIL wr_addr: got %0d expected %0d", wr_addr, m_wr[AW-1:0]); end
    checks++; if (rd_addr !== m_rd[AW-1:0]) begin errors++; $display("FAIL rd_addr: got %0d expected %0d", rd_addr, m_rd[AW-1:0]); end
    if (er) begin
      got = mem[rd_addr];
      expd = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      checks++; if (got !== expd) begin errors++; $display("FAIL rd_data: got %0h expected %0h", got, expd); end
    end
    if (ew) sb.push_back(wdata);
    @(posedge clk); #1;
`ifdef GRAY_FIFO_CTRL_ERR_EN
    if (p && m_occ == DEPTH) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (q && m_occ == 0)     m_unf = 1'b1; else if (c) m_unf = 1'b0;
    checks++; if (err_overflow !== m_ovf) begin errors++; $display("FAIL err_overflow: got %b expected %b", err_overflow, m_ovf); end
    checks++; if (err_underflow !== m_unf) begin errors++; $display("FAIL err_underflow: got %b expected %b", err_underflow, m_unf); end
`endif
    if (ew) begin m_wr = m_wr + 3'd1; m_occ++; end
    if (er) begin m_rd = m_rd + 3'd1; m_occ--; end
    gw = m_wr ^ (m_wr >> 1);
    gr = m_rd ^ (m_rd >> 1);
    checks++; if (count !== (AW+1)'(m_occ)) begin errors++; $display("FAIL count: got %0d expected %0d", count, m_occ); end
    checks++; if (full !== (m_occ == DEPTH)) begin errors++; $display("FAIL full: got %b expected %b", full, m_occ == DEPTH); end
    checks++; if (empty !== (m_occ == 0)) begin errors++; $display("FAIL empty: got %b expected %b", empty, m_occ == 0); end
    checks++; if (wr_ptr_gray !== gw) begin errors++; $display("FAIL wr_ptr_gray: got %b expected %b", wr_ptr_gray, gw); end
    checks++; if (rd_ptr_gray !== gr) begin errors++; $display("FAIL rd_ptr_gray: got %b expected %b", rd_ptr_gray, gr); end
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1; push = 1'b1; pop = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    @(posedge clk); #1;
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b expected empty=1 full=0", empty, full); end
    checks++; if (count !== 3'd0 || wr_ptr_gray !== 3'd0 || rd_ptr_gray !== 3'd0) begin errors++; $display("FAIL reset_ptrs: got count=%0d wg=%b rg=%b expected 0", count, wr_ptr_gray, rd_ptr_gray); end
    @(negedge clk); reset = 1'b0; push = 1'b0; pop = 1'b0;
    model_reset();
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b1, 1'b0);
    checks++; if (rd_ptr_gray !== 3'b000) begin errors++; $display("FAIL underflow_rd_ptr: got %b expected 000", rd_ptr_gray); end
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL fill_flags: got full=%b empty=%b expected full=1 empty=0", full, empty); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    checks++; if (wr_ptr_gray !== 3'b110) begin errors++; $display("FAIL fill_wr_gray: got %b expected 110", wr_ptr_gray); end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    checks++; if (wr_ptr_gray !== 3'b110) begin errors++; $display("FAIL overflow_wr_gray: got %b expected 110", wr_ptr_gray); end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_full_push_pop();
    cycle(1'b1, 1'b1, 1'b0);
    checks++; if (count !== 3'd3 || full !== 1'b0) begin errors++; $display("FAIL full_pushpop: got count=%0d full=%b expected count=3 full=0", count, full); end
  endtask

  task automatic test_wrap();
    logic [AW:0] prev;
    logic        wrapped = 1'b0;
    while (m_occ > 1) cycle(1'b0, 1'b1, 1'b0);
    prev = wr_ptr_gray;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++; if ($countones(prev ^ wr_ptr_gray) != 1) begin errors++; $display("FAIL gray_step: got %b -> %b expected one-bit change", prev, wr_ptr_gray); end
      if (prev == 3'b100 && wr_ptr_gray == 3'b000) wrapped = 1'b1;
      prev = wr_ptr_gray;
    end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count: got %0d expected 1", count); end
    checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_seen: got %b expected 1", wrapped); end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
    @(negedge clk); push = 1'b1; pop = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL pre_reset_wr_en: got %b expected 1", wr_en); end
    #2 reset = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL async_wr_en: got %b expected 0", wr_en); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL async_flags: got empty=%b full=%b expected empty=1 full=0", empty, full); end
    checks++; if (count !== 3'd0 || wr_ptr_gray !== 3'd0) begin errors++; $display("FAIL async_ptrs: got count=%0d wg=%b expected 0", count, wr_ptr_gray); end
    @(negedge clk); reset = 1'b0; push = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_underflow();
    test_fill();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
